// File: rtl/alu_pipe.sv
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage valid/ready ALU pipeline. S1 captures the operand
//                set, S2 captures the result and its flags. Optional signed
//                saturation of ADD/SUB is enabled by defining ALU_PIPE_SAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_pipe #(
    parameter int WIDTH = 32,               // 8, 16, 32 or 64
    parameter int SHW   = $clog2(WIDTH)     // shift amount taken from b[SHW-1:0]
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             cout,
    output logic             illegal,
    input  logic             clr_sticky,
    output logic             ovf_sticky
);

    localparam logic [3:0] c_op_bypassa = 4'd0;
    localparam logic [3:0] c_op_bypassb = 4'd1;
    localparam logic [3:0] c_op_add     = 4'd2;
    localparam logic [3:0] c_op_sub     = 4'd3;
    localparam logic [3:0] c_op_nota    = 4'd4;
    localparam logic [3:0] c_op_and     = 4'd5;
    localparam logic [3:0] c_op_orr     = 4'd6;
    localparam logic [3:0] c_op_xor     = 4'd7;
    localparam logic [3:0] c_op_sll     = 4'd8;
    localparam logic [3:0] c_op_srl     = 4'd9;
    localparam logic [3:0] c_op_sra     = 4'd10;
    localparam logic [3:0] c_op_slt     = 4'd11;

    localparam logic [WIDTH:0]   c_one_ext = {{WIDTH{1'b0}}, 1'b1};
`ifdef ALU_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] c_smax    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_smin    = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Stage 1 operand registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [3:0]       r_s1_op;

    // Stage 2 occupancy; result and flags live directly in the output ports
    logic             r_s2_valid;

    logic             w_s1_adv;
    logic             w_in_xfer;
    logic             w_out_xfer;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_cout;
    logic             w_ill;

    // S1 moves forward when S2 is empty or is draining this cycle
    assign w_s1_adv   = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready   = !r_s1_valid || w_s1_adv;
    assign w_in_xfer  = in_valid && in_ready;
    assign out_valid  = r_s2_valid;
    assign w_out_xfer = r_s2_valid && out_ready;

    // Carry-extended arithmetic; SUB is a + ~b + 1 so cout=1 means no borrow
    assign w_sum   = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_diff  = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + c_one_ext;
    assign w_shamt = r_s1_b[SHW-1:0];

    // Execute the S1 operation; flags other than overflow/cout come from w_res later
    always_comb begin
        w_res  = '0;
        w_ovf  = 1'b0;
        w_cout = 1'b0;
        w_ill  = 1'b0;
        case (r_s1_op)
            c_op_bypassa: w_res = r_s1_a;
            c_op_bypassb: w_res = r_s1_b;
            c_op_add: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            c_op_sub: begin
                w_res  = w_diff[WIDTH-1:0];
                w_cout = w_diff[WIDTH];
                w_ovf  = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                         (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            c_op_nota:    w_res = ~r_s1_a;
            c_op_and:     w_res = r_s1_a & r_s1_b;
            c_op_orr:     w_res = r_s1_a | r_s1_b;
            c_op_xor:     w_res = r_s1_a ^ r_s1_b;
            c_op_sll:     w_res = r_s1_a << w_shamt;
            c_op_srl:     w_res = r_s1_a >> w_shamt;
            c_op_sra:     w_res = $signed(r_s1_a) >>> w_shamt;
            c_op_slt:     w_res = {{(WIDTH-1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
            default:      w_ill = 1'b1;
        endcase
`ifdef ALU_PIPE_SAT_EN
        // Overflow only arises on ADD/SUB; the sign of a tells the direction
        if (w_ovf) begin
            w_res = r_s1_a[WIDTH-1] ? c_smin : c_smax;
        end
`endif
    end

    // Stage 1: capture the operand set on input transfer, drop it when it advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
        end else begin
            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= a;
                r_s1_b     <= b;
                r_s1_op    <= op;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: register result and flags; hold them while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            result     <= '0;
            negative   <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            cout       <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                result     <= w_res;
                negative   <= w_res[WIDTH-1];
                zero       <= (w_res == '0);
                overflow   <= w_ovf;
                cout       <= w_cout;
                illegal    <= w_ill;
            end else if (w_out_xfer) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    // Sticky overflow: a transferred overflow beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (w_out_xfer && overflow) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Scoreboard bench for alu_pipe (WIDTH=32).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         negative;
    logic         zero;
    logic         overflow;
    logic         cout;
    logic         illegal;
    logic         clr_sticky;
    logic         ovf_sticky;

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .negative   (negative),
        .zero       (zero),
        .overflow   (overflow),
        .cout       (cout),
        .illegal    (illegal),
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } txn_t;

    txn_t        tx_q[$];
    logic [36:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [36:0] hold;
    bit          have_hold = 1'b0;

    // Reference model: {result, negative, zero, overflow, cout, illegal}
    function automatic logic [36:0] model(input txn_t t);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] full;
        logic [63:0]        u;
        logic [31:0]        r;
        logic               ov;
        logic               co;
        logic               il;
        sa = {{32{t.a[31]}}, t.a};
        sb = {{32{t.b[31]}}, t.b};
        r  = '0;
        ov = 1'b0;
        co = 1'b0;
        il = 1'b0;
        case (t.op)
            4'd0:  r = t.a;
            4'd1:  r = t.b;
            4'd2: begin
                full = sa + sb;
                r    = full[31:0];
                ov   = (full > 64'sd2147483647) || (full < -64'sd2147483648);
                u    = {32'd0, t.a} + {32'd0, t.b};
                co   = u[32];
`ifdef ALU_PIPE_SAT_EN
                if (ov) r = (full > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
            end
            4'd3: begin
                full = sa - sb;
                r    = full[31:0];
                ov   = (full > 64'sd2147483647) || (full < -64'sd2147483648);
                co   = (t.a >= t.b);
`ifdef ALU_PIPE_SAT_EN
                if (ov) r = (full > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
            end
            4'd4:  r = ~t.a;
            4'd5:  r = t.a & t.b;
            4'd6:  r = t.a | t.b;
            4'd7:  r = t.a ^ t.b;
            4'd8:  r = t.a << t.b[4:0];
            4'd9:  r = t.a >> t.b[4:0];
            4'd10: r = $signed(t.a) >>> t.b[4:0];
            4'd11: r = (sa < sb) ? 32'd1 : 32'd0;
            default: il = 1'b1;
        endcase
        return {r, r[31], (r == 32'd0), ov, co, il};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Present the head of the stimulus queue (held until accepted)
    task automatic drive();
        if (tx_q.size() > 0) begin
            in_valid = 1'b1;
            a        = tx_q[0].a;
            b        = tx_q[0].b;
            op       = tx_q[0].op;
        end else begin
            in_valid = 1'b0;
            a        = '0;
            b        = '0;
            op       = '0;
        end
    endtask

    // One clock: sample at negedge, scoreboard transfers, re-drive after posedge
    task automatic tick();
        logic [36:0] obs;
        logic [36:0] e;
        @(negedge clk);
        obs = {result, negative, zero, overflow, cout, illegal};
        if (have_hold && out_valid) chk("hold_stable", {27'd0, obs}, {27'd0, hold});
        have_hold = out_valid && !out_ready;
        hold      = obs;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", {63'd0, out_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result_flags", {27'd0, obs}, {27'd0, e});
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(tx_q.pop_front()));
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (tx_q.size() == 0 && exp_q.size() == 0) break;
            tick();
        end
        chk("drain_pending", 64'(tx_q.size() + exp_q.size()), 64'd0);
    endtask

    function automatic txn_t mk(input logic [31:0] xa, input logic [31:0] xb, input logic [3:0] xop);
        txn_t t;
        t.a  = xa;
        t.b  = xb;
        t.op = xop;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        drive();
        #12;
        // Reset state
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_outputs", {27'd0, result, negative, zero, overflow, cout, illegal}, 64'd0);
        chk("rst_sticky", {63'd0, ovf_sticky}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

        // ADD overflow: latency and sticky
        tx_q.push_back(mk(32'h7FFF_FFFF, 32'd1, 4'd2));
        drive();
        tick();
        chk("latency_c1", {63'd0, out_valid}, 64'd0);
        tick();
        chk("latency_c2", {63'd0, out_valid}, 64'd1);
        tick();
        chk("sticky_set", {63'd0, ovf_sticky}, 64'd1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("sticky_clear", {63'd0, ovf_sticky}, 64'd0);

        // Opcode sweep streamed back-to-back
        tx_q.push_back(mk(32'd5, 32'd5, 4'd3));
        tx_q.push_back(mk(32'd0, 32'd1, 4'd3));
        tx_q.push_back(mk(32'h8000_0000, 32'h0000_0024, 4'd10));
        tx_q.push_back(mk(32'hFFFF_FFFF, 32'd0, 4'd11));
        tx_q.push_back(mk(32'h0000_1234, 32'd5, 4'hD));
        tx_q.push_back(mk(32'd3, 32'd4, 4'd2));
        tx_q.push_back(mk(32'hF0F0_1234, 32'h0FF0_FF00, 4'd5));
        tx_q.push_back(mk(32'hF0F0_1234, 32'h0FF0_FF00, 4'd6));
        tx_q.push_back(mk(32'hF0F0_1234, 32'hF0F0_1234, 4'd7));
        tx_q.push_back(mk(32'h1234_5678, 32'd0, 4'd4));
        tx_q.push_back(mk(32'h8000_0001, 32'hFFFF_FFE3, 4'd8));
        tx_q.push_back(mk(32'h8000_0001, 32'd31, 4'd9));
        tx_q.push_back(mk(32'hAAAA_5555, 32'd7, 4'd0));
        tx_q.push_back(mk(32'hAAAA_5555, 32'd7, 4'd1));
        tx_q.push_back(mk(32'd1, 32'hFFFF_FFFF, 4'd11));
        tx_q.push_back(mk(32'h8000_0000, 32'd1, 4'd3));
        tx_q.push_back(mk(32'd9, 32'd9, 4'hF));
        drive();
        drain();

        // Four ops with a 3-cycle consumer stall after the first result
        tx_q.push_back(mk(32'd1, 32'd2, 4'd2));
        tx_q.push_back(mk(32'd10, 32'd3, 4'd3));
        tx_q.push_back(mk(32'hFF00_FF00, 32'h0F0F_0F0F, 4'd7));
        tx_q.push_back(mk(32'd3, 32'd4, 4'd8));
        drive();
        tick();
        tick();
        out_ready = 1'b0;
        #1;
        chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        tick();
        tick();
        chk("stall_in_ready_held", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        drain();

        // Overflow transfer coinciding with clear: set wins
        clr_sticky = 1'b1;
        tx_q.push_back(mk(32'h8000_0000, 32'h8000_0000, 4'd2));
        drive();
        tick();
        tick();
        chk("sticky_pre_set", {63'd0, ovf_sticky}, 64'd0);
        tick();
        chk("sticky_set_wins", {63'd0, ovf_sticky}, 64'd1);
        clr_sticky = 1'b0;
        drain();

        // Reset with two operand sets in flight
        out_ready = 1'b0;
        tx_q.push_back(mk(32'd1, 32'd1, 4'd2));
        tx_q.push_back(mk(32'd7, 32'd2, 4'd3));
        drive();
        tick();
        tick();
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_sticky", {63'd0, ovf_sticky}, 64'd0);
        chk("mid_rst_result", {32'd0, result}, 64'd0);
        exp_q.delete();
        tx_q.delete();
        have_hold = 1'b0;
        drive();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_idle", {63'd0, out_valid}, 64'd0);
        tx_q.push_back(mk(32'd2, 32'd3, 4'd2));
        drive();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be one of 8, 16, 32 or 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from B[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 op  input  4  opcode: 0 BYPASSA, 1 BYPASSB, 2 ADD, 3 SUB, 4 NOT A, 5 AND, 6 ORR, 7 XOR, 8 SLL, 9 SRL, 10 SRA, 11 SLT (signed), 12-15 illegal.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 negative, zero, overflow, cout, illegal  output  1 each  per-result flags.
REQ-013 clr_sticky  input  1  clears ovf_sticky.
REQ-014 ovf_sticky  output  1  set on any transferred result with overflow=1.

Function
REQ-015 The block SHALL be a 2-stage pipeline: S1 registers a, b, op; S2 registers result and flags.
REQ-016 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-017 in_ready SHALL equal !s1_valid || s1_adv, where s1_adv = s1_valid && (!s2_valid || out_ready); purely combinational from registered state and out_ready.
REQ-018 With out_ready held high, latency SHALL be 2 cycles from input transfer to out_valid, at 1 result per cycle.
REQ-019 When out_valid && !out_ready, result and all flags SHALL stay stable until transfer; no operand set is dropped or duplicated.
REQ-020 ADD/SUB SHALL compute on WIDTH+1 bits; cout = bit WIDTH (SUB: carry of a + ~b + 1, i.e. 1 means no borrow).
REQ-021 overflow SHALL follow signed rules (ADD: a,b same sign, result sign differs; SUB: a,b differ, result sign differs from a); overflow and cout SHALL be 0 for all other opcodes.
REQ-022 Shifts SHALL use b[SHW-1:0] only; SRA replicates a[WIDTH-1]; SLT result = 1 if signed a < signed b, else 0.
REQ-023 Illegal opcodes SHALL produce result 0, illegal=1, zero=1, all other flags 0, and SHALL still occupy one pipeline slot.
REQ-024 negative = result[WIDTH-1]; zero = (result == 0); flags SHALL be computed from the final (post-saturation, if enabled) result.
REQ-025 ovf_sticky SHALL set on an output transfer with overflow=1 and clear on clr_sticky; when both occur in one cycle, set wins.

Reset
REQ-026 While rst_n is low, s1_valid, s2_valid, out_valid and ovf_sticky SHALL be 0; result and flags SHALL be 0.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deassertion.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operand sets; none emerge after release.

Configuration
REQ-029 Macro ALU_PIPE_SAT_EN: when defined, ADD/SUB with overflow SHALL saturate result to the signed maximum (positive overflow) or minimum (negative overflow), overflow still reported as 1.
REQ-030 Without ALU_PIPE_SAT_EN, ADD/SUB results SHALL wrap modulo 2^WIDTH.

Verification
REQ-031 WIDTH=32, ADD a=32'h7FFF_FFFF b=1, out_ready=1 -> 2 cycles later result=32'h8000_0000 (32'h7FFF_FFFF with SAT_EN), overflow=1, ovf_sticky=1 the following cycle.
REQ-032 SUB a=5 b=5 -> result=0, zero=1, cout=1, overflow=0; SUB a=0 b=1 -> result=32'hFFFF_FFFF, negative=1, cout=0.
REQ-033 SRA a=32'h8000_0000 b=32'h0000_0024 (shift 4) -> result=32'hF800_0000; SLT a=-1 b=0 -> result=1.
REQ-034 Stream 4 ops back-to-back, out_ready low for 3 cycles after the first out_valid -> in_ready drops after 2 accepted beyond the output, all 4 results emerge in order, held stable while stalled.
REQ-035 op=4'hD -> result=0, illegal=1, zero=1; pipeline continues with next op unaffected.
REQ-036 Assert rst_n low with 2 ops in flight -> out_valid=0 and ovf_sticky=0 immediately; no stale result after release.
